lsu_bus_master: RTL

- Load/store initiator between the CPU data path and the byte-addressable data RAM slave (cs/we/addr/BHW/wdata/rdata interface).
- Accepts one CPU load/store request at a time through a valid/ready handshake and range-checks it against the RAM window.
- Drives one registered bus access, then returns sign- or zero-extended load data (or a store acknowledge) through a valid/ready response channel.

---
 rtl/lsu_bus_master_pkg.sv | 49 ++++
 rtl/lsu_load_ext.sv | 23 ++
 rtl/lsu_bus_master.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lsu_bus_master_pkg.sv
// Shared definitions for the LSU bus master: size codes, funct3 codes,
// FSM state encoding and small decode helpers.
package lsu_bus_master_pkg;

   // Bus access size codes (bus_bhw)
   localparam logic [1:0] SL_BYTE = 2'b00;
   localparam logic [1:0] SL_HALF = 2'b01;
   localparam logic [1:0] SL_WORD = 2'b10;

   // RV32I load/store funct3 codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StAccess = 2'b01,
      StResp   = 2'b10
   } lsu_state_e;

   // Number of bytes touched; 0 marks an undefined funct3
   function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
      case (funct3)
         F3_LB, F3_LBU: size_bytes = 3'd1;
         F3_LH, F3_LHU: size_bytes = 3'd2;
         F3_LW:         size_bytes = 3'd4;
         default:       size_bytes = 3'd0;
      endcase
   endfunction

   function automatic logic [1:0] size_code(input logic [2:0] funct3);
      case (funct3)
         F3_LH, F3_LHU: size_code = SL_HALF;
         F3_LW:         size_code = SL_WORD;
         default:       size_code = SL_BYTE;
      endcase
   endfunction

   // Unsigned variants only exist for loads
   function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
      funct3_legal = (size_bytes(funct3) != 3'd0) && !(we && funct3[2]);
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extension selected by the RV32I funct3 code.
module lsu_load_ext
   import lsu_bus_master_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   // Sign/zero extend the low byte or half; words pass through
   always_comb begin
      data = '0;
      case (funct3)
         F3_LB:   data = {{24{rdata[7]}}, rdata[7:0]};
         F3_LBU:  data = {24'd0, rdata[7:0]};
         F3_LH:   data = {{16{rdata[15]}}, rdata[15:0]};
         F3_LHU:  data = {16'd0, rdata[15:0]};
         F3_LW:   data = rdata;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store initiator: one CPU request at a time, range-checked against the
// RAM window, one registered bus access, then a held response.
module lsu_bus_master
   import lsu_bus_master_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int unsigned WIN_BYTES = 256,
   parameter int unsigned BUS_AW    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              bus_cs,
   output logic              bus_we,
   output logic [BUS_AW-1:0] bus_addr,
   output logic [1:0]        bus_bhw,
   output logic [31:0]       bus_wdata,
   input  logic [31:0]       bus_rdata
);

   lsu_state_e        state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              cs_q, cs_d;
   logic              we_q, we_d;
   logic [BUS_AW-1:0] addr_q, addr_d;
   logic [1:0]        bhw_q, bhw_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [31:0]       offset;
   logic [31:0]       last_ok;
   logic              req_legal;
   logic [31:0]       ext_data;

   lsu_load_ext u_load_ext (
      .funct3 (funct3_q),
      .rdata  (bus_rdata),
      .data   (ext_data)
   );

   // Range check: addresses below the base wrap to huge offsets and fail too
   always_comb begin
      offset    = req_addr - BASE_ADDR;
      last_ok   = WIN_BYTES - {29'd0, size_bytes(req_funct3)};
      req_legal = funct3_legal(req_we, req_funct3) && (offset <= last_ok);
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d  = state_q;
      funct3_d = funct3_q;
      cs_d     = 1'b0;
      we_d     = 1'b0;
      addr_d   = '0;
      bhw_d    = '0;
      wdata_d  = '0;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               funct3_d = req_funct3;
               if (req_legal) begin
                  state_d = StAccess;
                  cs_d    = 1'b1;
                  we_d    = req_we;
                  addr_d  = offset[BUS_AW-1:0];
                  bhw_d   = size_code(req_funct3);
                  wdata_d = req_wdata;
               end else begin
                  state_d = StResp;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         StAccess: begin
            state_d = StResp;
            err_d   = 1'b0;
            rdata_d = we_q ? 32'd0 : ext_data;
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
               err_d   = 1'b0;
               rdata_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; async reset also kills an in-flight access
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         funct3_q <= '0;
         cs_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         bhw_q    <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         funct3_q <= funct3_d;
         cs_q     <= cs_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         bhw_q    <= bhw_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign bus_cs    = cs_q;
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_bhw   = bhw_q;
   assign bus_wdata = wdata_q;

endmodule
